// File: rtl/run_pkg.sv
// rtl/run_pkg.sv - shared states, shape codes and lane/screen constants for the running-man controller
package run_pkg;

   typedef enum logic [2:0] {
      S_FLOORS,
      S_WAIT,
      S_ERASE,
      S_TREE,
      S_MAN,
      S_UPDATE,
      S_OVER
   } state_t;

   localparam logic [1:0] SHP_TOP_GAP = 2'b00;
   localparam logic [1:0] SHP_BOT_GAP = 2'b10;
   localparam logic [1:0] SHP_WALL    = 2'b11;

   localparam logic [6:0] Y_LANE0 = 7'd28;
   localparam logic [6:0] Y_LANE1 = 7'd68;
   localparam logic [6:0] Y_LANE2 = 7'd108;

   localparam logic [7:0] SCREEN_X_MAX = 8'd159;
   localparam logic [6:0] SCREEN_Y_MAX = 7'd119;

   function automatic logic [6:0] lane_to_y(input logic [1:0] lane);
      case (lane)
         2'd0:    return Y_LANE0;
         2'd1:    return Y_LANE1;
         default: return Y_LANE2;
      endcase
   endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// rtl/obstacle_lfsr.sv - 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) supplying obstacle shape bits
module obstacle_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       step,
   output logic [5:0] shape_bits
);

   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset || load) begin
         lfsr <= SEED;
      end else if (step) begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign shape_bits = lfsr[5:0];

endmodule

// File: rtl/run_frame_ctrl.sv
// rtl/run_frame_ctrl.sv - per-frame draw sequencer with obstacle scroll, player input and collision
module run_frame_ctrl
   import run_pkg::*;
#(
   parameter int unsigned  FRAME_CYCLES = 833333,
   parameter logic [7:0]   TREE_STEP    = 8'd1,
   parameter logic [7:0]   TREE_START_X = 8'd156,
   parameter logic [7:0]   MAN_X        = 8'd25,
   parameter logic [15:0]  LFSR_SEED    = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_crouch,
   input  logic       key_start,
   input  logic       draw_floors_finish,
   input  logic       erase_finish,
   input  logic       draw_tree_finish,
   input  logic       draw_man_finish,
   output logic       drawing_floors,
   output logic       erase,
   output logic       draw_tree,
   output logic       draw_man,
   output logic       gameover,
   output logic       ld_x,
   output logic [7:0] x_in,
   output logic       ld_y,
   output logic [6:0] y_in,
   output logic       ld_man_style,
   output logic       man_style,
   output logic       ld_shape,
   output logic [1:0] top,
   output logic [1:0] mid,
   output logic [1:0] bottom,
   output logic [7:0] score
);

   localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] frame_cnt;
   logic             frame_tick;
   logic             up_q, down_q, start_q, up_lat, down_lat;
   logic             up_edge, down_edge, start_edge;
   logic             restart, do_update, reload, overlap, collide;
   logic [1:0]       lane, lane_nxt, lane_shape;
   logic [5:0]       shape_bits;

   assign frame_tick = (frame_cnt == CNT_LAST);
   assign up_edge    = key_up & ~up_q;
   assign down_edge  = key_down & ~down_q;
   assign start_edge = key_start & ~start_q;
   assign restart    = (state == S_OVER) && start_edge;
   assign do_update  = (state == S_UPDATE);
   assign reload     = do_update && (x_in < TREE_STEP);

   obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .load       (1'b0),
      .step       (reload),
      .shape_bits (shape_bits)
   );

   // Frame timebase and key history keep running through game-over and restart.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         up_q      <= 1'b0;
         down_q    <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;
         up_q      <= key_up;
         down_q    <= key_down;
         start_q   <= key_start;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_FLOORS;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      drawing_floors = 1'b0;
      erase          = 1'b0;
      draw_tree      = 1'b0;
      draw_man       = 1'b0;
      gameover       = 1'b0;
      case (state)
         S_FLOORS: begin
            drawing_floors = ~draw_floors_finish;
            if (draw_floors_finish) state_nxt = S_WAIT;
         end
         S_WAIT:   if (frame_tick) state_nxt = S_ERASE;
         S_ERASE: begin
            erase = ~erase_finish;
            if (erase_finish) state_nxt = S_TREE;
         end
         S_TREE: begin
            draw_tree = ~draw_tree_finish;
            if (draw_tree_finish) state_nxt = S_MAN;
         end
         S_MAN: begin
            draw_man = ~draw_man_finish;
            if (draw_man_finish) state_nxt = S_UPDATE;
         end
         S_UPDATE: state_nxt = collide ? S_OVER : S_WAIT;
         S_OVER: begin
            gameover = 1'b1;
            if (start_edge) state_nxt = S_FLOORS;
         end
         default:  state_nxt = S_FLOORS;
      endcase
   end

   always_comb begin
      case (lane)
         2'd0:    lane_shape = top;
         2'd1:    lane_shape = mid;
         default: lane_shape = bottom;
      endcase
   end

   // Collision sees the frame as drawn: pre-update tree position, lane and stance.
   assign overlap = ({1'b0, x_in} + 9'd1 >= {1'b0, MAN_X}) && ({1'b0, x_in} <= {1'b0, MAN_X} + 9'd6);
   assign collide = overlap && ((lane_shape == SHP_WALL) || ((lane_shape == SHP_BOT_GAP) && man_style));

   always_comb begin
      lane_nxt = lane;
      if (up_lat && !down_lat && (lane != 2'd0))      lane_nxt = lane - 2'd1;
      else if (down_lat && !up_lat && (lane != 2'd2)) lane_nxt = lane + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         x_in         <= TREE_START_X;
         lane         <= 2'd2;
         y_in         <= Y_LANE2;
         man_style    <= 1'b1;
         top          <= SHP_TOP_GAP;
         mid          <= SHP_BOT_GAP;
         bottom       <= SHP_WALL;
         score        <= 8'd0;
         ld_x         <= 1'b0;
         ld_y         <= 1'b0;
         ld_man_style <= 1'b0;
         ld_shape     <= 1'b0;
         up_lat       <= 1'b0;
         down_lat     <= 1'b0;
      end else begin
         ld_x         <= do_update;
         ld_y         <= do_update;
         ld_man_style <= do_update;
         ld_shape     <= reload;
         if (do_update) begin
            x_in <= reload ? TREE_START_X : x_in - TREE_STEP;
            if (reload) begin
               top    <= shape_bits[5:4];
               mid    <= shape_bits[3:2];
               // A solid column would be unpassable; open the bottom lane instead.
               bottom <= (shape_bits == 6'h3F) ? SHP_BOT_GAP : shape_bits[1:0];
               if (score != 8'hFF) score <= score + 8'd1;
            end
            lane      <= lane_nxt;
            y_in      <= lane_to_y(lane_nxt);
            man_style <= ~key_crouch;
            up_lat    <= up_edge;
            down_lat  <= down_edge;
         end else begin
            if (up_edge)   up_lat   <= 1'b1;
            if (down_edge) down_lat <= 1'b1;
         end
      end
   end

endmodule

// File: doc/run_frame_ctrl.md
Name: run_frame_ctrl

Overview:
- Per-frame sequencer for the running-man pixel datapath. Issues the draw strobes in order (floors, erase, tree, man) and waits on each datapath finish flag.
- Between frames it scrolls the obstacle (tree), loads new obstacle shapes, and applies player lane/stance input.
- Detects collisions and holds the datapath in game-over until restart.
- Sits between the key/input logic and the datapath; owns every datapath control and load input.

Parameters:
- FRAME_CYCLES, 833333, clk cycles per frame tick (60 Hz at 50 MHz).
- TREE_STEP, 1, pixels the tree moves left per frame.
- TREE_START_X, 156, tree x reload value.
- MAN_X, 25, fixed man x origin; collision window is MAN_X..MAN_X+6.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_up  in  1  level; rising edge requests a move one lane up
- key_down  in  1  level; rising edge requests a move one lane down
- key_crouch  in  1  level; 1 = crouch stance, 0 = normal
- key_start  in  1  level; rising edge restarts from game-over
- draw_floors_finish, erase_finish, draw_tree_finish, draw_man_finish  in  1 each  datapath finish flags (sticky)
- drawing_floors, erase, draw_tree, draw_man, gameover  out  1 each  datapath mode strobes (level, at most one high)
- ld_x  out  1  load tree x (pulse)
- x_in  out  8  tree x value
- ld_y  out  1  load man y (pulse)
- y_in  out  7  man y value
- ld_man_style, man_style  out  1 each  stance load pulse / value (1 normal, 0 crouch)
- ld_shape  out  1  load shapes (pulse)
- top, mid, bottom  out  2 each  shape codes: 00/01 top gap, 10 bottom gap, 11 wall
- score  out  8  obstacles passed, saturating at 255

Behaviour:
- Reset (synchronous, active-high):
  - state = S_FLOORS.
  - All strobes and ld_* = 0.
  - tree_x = TREE_START_X, lane = 2 (bottom), y_in = 108, man_style = 1.
  - top/mid/bottom = 00/10/11, score = 0.
  - Frame counter = 0, LFSR = LFSR_SEED, key edge registers = 0.
- Lane to man y: lane 0 = 28, lane 1 = 68, lane 2 = 108.
- Frame counter counts 0..FRAME_CYCLES-1 and wraps. frame_tick is high for one cycle at wrap. It runs in every state.
- States and transitions:
  - S_FLOORS: drawing_floors = 1 until draw_floors_finish = 1, then go to S_WAIT.
  - S_WAIT: all strobes 0. On frame_tick go to S_ERASE.
  - S_ERASE: erase = 1 until erase_finish = 1, then go to S_TREE.
  - S_TREE: draw_tree = 1 until draw_tree_finish = 1, then go to S_MAN.
  - S_MAN: draw_man = 1 until draw_man_finish = 1, then go to S_UPDATE.
  - S_UPDATE: one cycle. Next state is S_OVER if a collision is detected, else S_WAIT.
  - S_OVER: gameover = 1. On a key_start rising edge, perform all reset actions except LFSR and frame counter, then go to S_FLOORS.
- Finish flag handling: a strobe drops in the same cycle its finish flag is sampled high. Flags are sticky and are cleared by the datapath. The controller never clears them.
- S_UPDATE actions, all in the same cycle:
  - Scroll: if tree_x < TREE_STEP, tree_x = TREE_START_X, ld_shape = 1 with shapes taken from LFSR[5:0], LFSR advances one step, score += 1 (saturating). Otherwise tree_x -= TREE_STEP. ld_x = 1 in both cases.
  - Shape rule: if all three LFSR-derived shapes = 11, bottom is forced to 10.
  - Lane: a latched up-edge decrements lane (floor 0); a latched down-edge increments lane (ceiling 2). If both are latched, lane is unchanged. ld_y = 1 and the latches clear.
  - Stance: man_style = ~key_crouch, ld_man_style = 1.
- Key edges: detected on every cycle and latched until consumed in S_UPDATE. Repeated edges within one frame count once.
- Collision: evaluated in S_UPDATE using the pre-update tree_x, lane, and stance. It applies when the tree overlaps the man: tree_x + 1 >= MAN_X and tree_x <= MAN_X + 6. Check the current lane's shape:
  - 11: always collides.
  - 10: collides unless crouch.
  - 00/01: never collides.
- Reset is sampled in any state. It aborts an in-progress draw and drops the strobe next cycle.
- Arithmetic: 8-bit unsigned; the underflow case is handled by the reload above.

Decomposition:
- Shared package run_pkg holds:
  - state enum;
  - shape codes SHP_TOP_GAP, SHP_BOT_GAP, SHP_WALL;
  - lane-to-y constants 28/68/108;
  - screen constants 159/119.
- One sub-module, obstacle_lfsr: 16-bit Galois LFSR (taps 16,14,13,11) with step enable and seed load, outputting 6 shape bits.

Test Plan:
- Reset, then hold draw_floors_finish = 0 for 50 cycles -> drawing_floors stays 1; set it to 1 -> next cycle S_WAIT, all strobes 0.
- FRAME_CYCLES = 20, finish flags returned 3 cycles after each strobe -> order erase, draw_tree, draw_man, then one-cycle ld_x with x_in = 155; next frame x_in = 154.
- tree_x = 0 at S_UPDATE -> x_in = 156, ld_shape = 1, score increments by 1. Force LFSR output to all-11 -> bottom = 10.
- Lane 2, key_up edge twice in one frame -> ld_y with y_in = 68; up edge at lane 0 -> y_in stays 28.
- Bottom = 11, lane 2, tree_x = 30 -> S_OVER with gameover = 1. Same case with shape 10 and key_crouch = 1 -> no collision.
- In S_OVER, key_start edge -> S_FLOORS, score = 0, x_in = 156, y_in = 108. Reset asserted mid-S_TREE -> draw_tree = 0 next cycle and state S_FLOORS.
